// File: rtl/dcache_pkg.sv
// Shared types and constants for the 2-way, 16-set data cache controller.
// Address layout: tag[31:9], index[8:5], word[4:2].
package dcache_pkg;

    localparam int LINE_W  = 256;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 23;
    localparam int WORD_W  = 3;
    localparam int TAGW_W  = TAG_W + 2;
    localparam int VALID_B = 24;
    localparam int DIRTY_B = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_ALLOCATE,
        S_REFILL
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[31:9];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return a[8:5];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [31:0] a);
        return a[4:2];
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] t,
                                              input logic [IDX_W-1:0] i);
        return {t, i, 5'b0};
    endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// Inserts one 32-bit word into a 256-bit cache line at a word index.
// Purely combinational; used for store hits and store-miss refills.
module dcache_line_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [31:0]       data_i,
    output logic [LINE_W-1:0] line_o
);

    // Overwrite the selected word, keep the rest of the line
    always_comb begin
        line_o = line_i;
        line_o[{word_i, 5'b0} +: 32] = data_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// Miss/writeback/refill control FSM in front of the dcache storage block.
// Optional DCACHE_STATS_EN adds hit/miss counters (stat_hit_o, stat_miss_o).
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    output logic [IDX_W-1:0]  sram_addr_o,
    output logic [TAGW_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    input  logic [TAGW_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hit_o,
    output logic [31:0]       stat_miss_o
`endif
);

    state_e            state_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [31:0]       mem_addr_q;
    logic [LINE_W-1:0] mem_data_q;
    logic [LINE_W-1:0] refill_q;

    logic              lookup;
    logic              hit_idle;
    logic              miss_idle;
    logic              refill_wr;
    logic [LINE_W-1:0] merge_base;
    logic [LINE_W-1:0] merged;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  cpu_idx;
    logic [WORD_W-1:0] cpu_word;
    logic              unused_addr_lsb;

    assign cpu_tag   = addr_tag(cpu_addr_i);
    assign cpu_idx   = addr_idx(cpu_addr_i);
    assign cpu_word  = addr_word(cpu_addr_i);
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign lookup    = (state_q == S_IDLE) && cpu_req_i && !rst_i;
    assign hit_idle  = lookup && sram_hit_i;
    assign miss_idle = lookup && !sram_hit_i;
    assign refill_wr = (state_q == S_REFILL) && !rst_i;

    assign merge_base = (state_q == S_REFILL) ? refill_q : sram_data_i;

    dcache_line_merge u_merge (
        .line_i (merge_base),
        .word_i (cpu_word),
        .data_i (cpu_data_i),
        .line_o (merged)
    );

    // Controller FSM; memory request outputs are registered here
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            refill_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (miss_idle) state_q <= S_MISS;
                end
                S_MISS: begin
                    mem_en_q <= 1'b1;
                    if (sram_tag_i[VALID_B] && sram_tag_i[DIRTY_B]) begin
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= line_addr(sram_tag_i[TAG_W-1:0], cpu_idx);
                        mem_data_q <= sram_data_i;
                        state_q    <= S_WRITEBACK;
                    end else begin
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= line_addr(cpu_tag, cpu_idx);
                        state_q    <= S_ALLOCATE;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= line_addr(cpu_tag, cpu_idx);
                        mem_data_q <= '0;
                        state_q    <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    if (mem_ack_i) begin
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                        refill_q   <= mem_data_i;
                        state_q    <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    assign cpu_stall_o = !rst_i && (miss_idle || (state_q != S_IDLE));
    assign cpu_data_o  = (hit_idle && !cpu_we_i) ?
                         sram_data_i[{cpu_word, 5'b0} +: 32] : '0;

    assign sram_enable_o = lookup || refill_wr ||
                           ((state_q == S_MISS) && !rst_i);
    assign sram_write_o  = (hit_idle && cpu_we_i) || refill_wr;
    assign sram_addr_o   = cpu_idx;
    assign sram_tag_o    = {1'b1, cpu_we_i, cpu_tag};
    assign sram_data_o   = !sram_write_o ? '0 :
                           cpu_we_i ? merged : refill_q;

`ifdef DCACHE_STATS_EN
    logic        relook_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Count first lookups only; the lookup right after a refill is skipped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            relook_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == S_REFILL) relook_q <= 1'b1;
            else if (lookup) relook_q <= 1'b0;
            if (lookup && !relook_q) begin
                if (sram_hit_i) hit_cnt_q <= hit_cnt_q + 32'd1;
                else miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign stat_hit_o  = hit_cnt_q;
    assign stat_miss_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench: flat-memory golden model, storage and memory models.
// Build with DCACHE_STATS_EN to also check the hit/miss counters.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  stat_hit_o;
    logic [31:0]  stat_miss_o;
`endif

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_stall_o   (cpu_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .sram_enable_o (sram_enable_o),
        .sram_write_o  (sram_write_o),
        .sram_addr_o   (sram_addr_o),
        .sram_tag_o    (sram_tag_o),
        .sram_data_o   (sram_data_o),
        .sram_tag_i    (sram_tag_i),
        .sram_data_i   (sram_data_i),
        .sram_hit_i    (sram_hit_i)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hit_o    (stat_hit_o),
        .stat_miss_o   (stat_miss_o)
`endif
    );

    typedef struct packed {
        logic         wr;
        logic [31:0]  a;
        logic [255:0] d;
    } mtx_t;

    typedef struct packed {
        logic [3:0]   a;
        logic [24:0]  t;
        logic [255:0] d;
    } stx_t;

    int vecs = 0;
    int errs = 0;
    int mem_lat = 2;
    logic mem_busy = 1'b0;

    logic [31:0]  rmem  [int];
    logic [255:0] mline [int];
    logic [31:0]  expq  [$];
    mtx_t         mlog  [$];
    stx_t         slog  [$];

    logic [24:0]  tagw  [2][16] = '{default: '0};
    logic [255:0] lines [2][16] = '{default: '0};
    logic         lru   [16]    = '{default: 1'b0};

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (rmem.exists(int'(a[31:2]))) return rmem[int'(a[31:2])];
        return init_word({a[31:2], 2'b00});
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] a);
        logic [255:0] l;
        if (mline.exists(int'(a[31:5]))) return mline[int'(a[31:5])];
        for (int i = 0; i < 8; i++)
            l[i*32 +: 32] = init_word({a[31:5], 5'b0} + 32'(i * 4));
        return l;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Storage model: 2-way set associative, LRU victim on miss
    logic [3:0] s_idx;
    logic       s_hit;
    logic       s_hw;
    logic       s_vw;
    always_comb begin
        s_idx = sram_addr_o;
        s_hit = 1'b0;
        s_hw  = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (tagw[w][s_idx][24] && tagw[w][s_idx][22:0] == sram_tag_o[22:0]) begin
                s_hit = 1'b1;
                s_hw  = w[0];
            end
        end
        s_vw        = s_hit ? s_hw : lru[s_idx];
        sram_hit_i  = s_hit;
        sram_tag_i  = tagw[s_vw][s_idx];
        sram_data_i = lines[s_vw][s_idx];
    end

    always @(posedge clk) begin
        stx_t e;
        if (sram_enable_o) begin
            if (sram_write_o) begin
                tagw[s_vw][s_idx]  <= sram_tag_o;
                lines[s_vw][s_idx] <= sram_data_o;
                lru[s_idx]         <= ~s_vw;
                e = '{a: sram_addr_o, t: sram_tag_o, d: sram_data_o};
                slog.push_back(e);
            end else if (s_hit) begin
                lru[s_idx] <= ~s_hw;
            end
        end
    end

    // Memory responder: ack after mem_lat cycles, commit writebacks on ack
    initial begin
        mtx_t m;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (mem_enable_o) begin
                mem_busy = 1'b1;
                m = '{wr: mem_write_o, a: mem_addr_o, d: mem_data_o};
                mlog.push_back(m);
                repeat (mem_lat) @(negedge clk);
                if (m.wr) mline[int'(m.a[31:5])] = m.d;
                else mem_data_i = get_line(m.a);
                mem_ack_i = 1'b1;
                @(negedge clk);
                mem_ack_i = 1'b0;
                mem_busy  = 1'b0;
            end
        end
    end

    // Monitor: every completed load is compared against the scoreboard
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst_i && cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
            vecs++;
            if (expq.size() == 0) begin
                errs++;
                $display("FAIL load_unexpected: got %h expected none", cpu_data_o);
            end else begin
                e = expq.pop_front();
                if (cpu_data_o !== e) begin
                    errs++;
                    $display("FAIL load_data @%h: got %h expected %h",
                             cpu_addr_i, cpu_data_o, e);
                end
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] d, output int stl);
        @(posedge clk);
        #1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = a;
        cpu_data_i = d;
        if (we) rmem[int'(a[31:2])] = d;
        else expq.push_back(ref_rd(a));
        stl = 0;
        forever begin
            @(negedge clk);
            if (!cpu_stall_o) break;
            stl++;
            if (stl > 200) begin
                vecs++;
                errs++;
                $display("FAIL access_timeout @%h: stalled %0d cycles", a, stl);
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int stl;
        int n;
        int n0;
        logic late_bad;
        stx_t s;
        mtx_t m;

        rst_i      = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0240;
        cpu_data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", cpu_stall_o, 0);
        chk("rst_mem_en", mem_enable_o, 0);
        chk("rst_sram_en", sram_enable_o, 0);
        chk("rst_data", cpu_data_o, 0);
        chk("rst_sram_addr", sram_addr_o, 2);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // T1: clean load miss with a 10-cycle memory wait
        mem_lat = 10;
        access(1'b0, 32'h0000_0040, 0, stl);
        chk("t1_stall_cycles", stl, 14);
        m = mlog[mlog.size()-1];
        chk("t1_alloc_wr", m.wr, 0);
        chk("t1_alloc_addr", m.a, 32'h40);
        s = slog[slog.size()-1];
        chk("t1_refill_tag", s.t, 25'h100_0000);
        chk("t1_refill_idx", s.a, 2);
        mem_lat = 2;

        // T2: store hit
        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, stl);
        chk("t2_stall", stl, 0);
        s = slog[slog.size()-1];
        chk("t2_tag_dirty", s.t, 25'h180_0000);
        chk("t2_word1", s.d[63:32], 32'hDEAD_BEEF);

        // T3: two conflicting loads; the second evicts the dirty line
        access(1'b0, 32'h0000_0240, 0, stl);
        n0 = mlog.size();
        access(1'b0, 32'h0000_0440, 0, stl);
        chk("t3_mem_ops", mlog.size(), n0 + 2);
        m = mlog[n0];
        chk("t3_wb_wr", m.wr, 1);
        chk("t3_wb_addr", m.a, 32'h40);
        chk("t3_wb_word1", m.d[63:32], 32'hDEAD_BEEF);
        m = mlog[n0+1];
        chk("t3_alloc_addr", m.a, 32'h440);
`ifdef DCACHE_STATS_EN
        chk("stat_hit", stat_hit_o, 1);
        chk("stat_miss", stat_miss_o, 3);
`endif

        // T4: store miss over a clean victim
        n0 = mlog.size();
        access(1'b1, 32'h0000_0844, 32'hCAFE_F00D, stl);
        chk("t4_no_wb", mlog.size(), n0 + 1);
        s = slog[slog.size()-1];
        chk("t4_refill_tag", s.t, 25'h180_0004);
        chk("t4_merged_word", s.d[63:32], 32'hCAFE_F00D);
        chk("t4_other_word", s.d[31:0], init_word(32'h840));

        // T5: reset during the refill wait, then a late ack
        mem_lat = 10;
        @(posedge clk);
        #1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_1000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_enable_o && n < 20);
        chk("t5_alloc_started", mem_enable_o, 1);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        @(negedge clk);
        chk("t5_mem_en", mem_enable_o, 0);
        chk("t5_stall", cpu_stall_o, 0);
        late_bad = 1'b0;
        n = 0;
        while (mem_busy && n < 50) begin
            @(negedge clk);
            n++;
            if (mem_enable_o || cpu_stall_o) late_bad = 1'b1;
        end
        chk("t5_late_ack_ignored", late_bad, 0);
        chk("t5_mem_idle", mem_busy, 0);
        repeat (2) @(negedge clk);
        chk("t5_still_idle", mem_enable_o | cpu_stall_o, 0);

        // Random traffic over a small conflict-heavy address pool
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = {23'($urandom_range(0, 5)), 4'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'b00};
            mem_lat = $urandom_range(1, 5);
            access(1'($urandom_range(0, 1)), a, $urandom, stl);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
